aes128_enc_core: RTL and testbench

AES128_ENC_CORE -- requirements
Module: aes128_enc_core

---
 rtl/aes128_enc_core.sv | 278 +++++++++++++++++++++++++++
 tb/tb_aes128_enc_core.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_enc_core.sv
`default_nettype none
// ============================================================================
// Module   : aes128_enc_core (plus aes_sbox, aes_sub_bytes, aes_shift_rows,
//            aes_mix_columns)
// Brief    : Iterative AES-128 encryption core, one round per clock, with
//            on-the-fly key expansion and valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif
`ifndef AES_WORD_SIZE
`define AES_WORD_SIZE 32
`endif

// ----------------------------------------------------------------------------
// Single AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// ----------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // x^254 == x^-1 for non-zero x, and 0 maps to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] w_inv;

    // Inverse then affine transform b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
    always_comb begin
        w_inv  = gf_inv(i_byte);
        o_byte = w_inv
               ^ {w_inv[6:0], w_inv[7]}
               ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]}
               ^ {w_inv[3:0], w_inv[7:4]}
               ^ 8'h63;
    end
endmodule

// ----------------------------------------------------------------------------
// SubBytes over the full 128-bit state.
// ----------------------------------------------------------------------------
module aes_sub_bytes (
    input  logic [`AES_BLOCK_SIZE-1:0] i_data,
    output logic [`AES_BLOCK_SIZE-1:0] o_data
);
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (i_data[127-8*gi -: 8]),
                .o_byte (o_data[127-8*gi -: 8])
            );
        end
    endgenerate
endmodule

// ----------------------------------------------------------------------------
// ShiftRows: row r of the column-major state rotates left by r columns.
// ----------------------------------------------------------------------------
module aes_shift_rows (
    input  logic [`AES_BLOCK_SIZE-1:0] i_data,
    output logic [`AES_BLOCK_SIZE-1:0] o_data
);
    genvar gc, gr;
    generate
        for (gc = 0; gc < 4; gc++) begin : g_col
            for (gr = 0; gr < 4; gr++) begin : g_row
                assign o_data[127-8*(4*gc+gr) -: 8] =
                    i_data[127-8*(4*((gc+gr)%4)+gr) -: 8];
            end
        end
    endgenerate
endmodule

// ----------------------------------------------------------------------------
// MixColumns: each column multiplied by the circulant {02,03,01,01} matrix.
// ----------------------------------------------------------------------------
module aes_mix_columns (
    input  logic [`AES_BLOCK_SIZE-1:0] i_data,
    output logic [`AES_BLOCK_SIZE-1:0] o_data
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    genvar gc;
    generate
        for (gc = 0; gc < 4; gc++) begin : g_col
            logic [7:0] w_a0, w_a1, w_a2, w_a3;
            assign w_a0 = i_data[127-32*gc      -: 8];
            assign w_a1 = i_data[127-32*gc-8    -: 8];
            assign w_a2 = i_data[127-32*gc-16   -: 8];
            assign w_a3 = i_data[127-32*gc-24   -: 8];
            // 3*a is computed as xtime(a) ^ a
            assign o_data[127-32*gc    -: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
            assign o_data[127-32*gc-8  -: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
            assign o_data[127-32*gc-16 -: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
            assign o_data[127-32*gc-24 -: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
        end
    endgenerate
endmodule

// ----------------------------------------------------------------------------
// Top: iterative AES-128 encryption core.
// ----------------------------------------------------------------------------
module aes128_enc_core (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [`AES_BLOCK_SIZE-1:0] in_block,
    input  logic [`AES_BLOCK_SIZE-1:0] in_key,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [`AES_BLOCK_SIZE-1:0] out_block
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [3:0] c_LAST_ROUND = 4'd10;

    logic [1:0]                 r_fsm;
    logic [1:0]                 w_fsm_next;
    logic [`AES_BLOCK_SIZE-1:0] r_state;
    logic [`AES_BLOCK_SIZE-1:0] r_key;
    logic [3:0]                 r_round;

    logic                       w_accept;
    logic                       w_last;
    logic [7:0]                 w_rcon;
    logic [`AES_WORD_SIZE-1:0]  w_kw0, w_kw1, w_kw2, w_kw3;
    logic [`AES_WORD_SIZE-1:0]  w_rot;
    logic [`AES_WORD_SIZE-1:0]  w_subword;
    logic [`AES_WORD_SIZE-1:0]  w_nw0, w_nw1, w_nw2, w_nw3;
    logic [`AES_BLOCK_SIZE-1:0] w_next_key;
    logic [`AES_BLOCK_SIZE-1:0] w_sb;
    logic [`AES_BLOCK_SIZE-1:0] w_sr;
    logic [`AES_BLOCK_SIZE-1:0] w_mc;
    logic [`AES_BLOCK_SIZE-1:0] w_round_out;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_round == c_LAST_ROUND);

    // Round constant for the round key being produced this cycle
    always_comb begin
        case (r_round)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // Key expansion: r_key holds round key r-1, the words below form round key r
    assign w_kw0 = r_key[127:96];
    assign w_kw1 = r_key[95:64];
    assign w_kw2 = r_key[63:32];
    assign w_kw3 = r_key[31:0];
    assign w_rot = {w_kw3[23:0], w_kw3[31:24]};

    genvar gk;
    generate
        for (gk = 0; gk < 4; gk++) begin : g_key_sbox
            aes_sbox u_key_sbox (
                .i_byte (w_rot[31-8*gk -: 8]),
                .o_byte (w_subword[31-8*gk -: 8])
            );
        end
    endgenerate

    assign w_nw0      = w_kw0 ^ w_subword ^ {w_rcon, 24'h000000};
    assign w_nw1      = w_kw1 ^ w_nw0;
    assign w_nw2      = w_kw2 ^ w_nw1;
    assign w_nw3      = w_kw3 ^ w_nw2;
    assign w_next_key = {w_nw0, w_nw1, w_nw2, w_nw3};

    aes_sub_bytes u_sub_bytes (
        .i_data (r_state),
        .o_data (w_sb)
    );

    aes_shift_rows u_shift_rows (
        .i_data (w_sb),
        .o_data (w_sr)
    );

    aes_mix_columns u_mix_columns (
        .i_data (w_sr),
        .o_data (w_mc)
    );

    // The final round skips MixColumns
    assign w_round_out = (w_last ? w_sr : w_mc) ^ w_next_key;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= c_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            c_IDLE:  if (w_accept) w_fsm_next = c_BUSY;
            c_BUSY:  if (w_last) w_fsm_next = c_DONE;
            c_DONE:  if (out_ready) w_fsm_next = c_IDLE;
            default: w_fsm_next = c_IDLE;
        endcase
    end

    // FSM outputs: pure decodes of the registered state
    always_comb begin
        in_ready  = (r_fsm == c_IDLE);
        out_valid = (r_fsm == c_DONE);
    end

    // Datapath: initial AddRoundKey on accept, one full round per BUSY cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
            r_key   <= '0;
            r_round <= 4'd0;
        end else if (w_accept) begin
            r_state <= in_block ^ in_key;
            r_key   <= in_key;
            r_round <= 4'd1;
        end else if (r_fsm == c_BUSY) begin
            r_state <= w_round_out;
            r_key   <= w_next_key;
            // Counter parks at 10 after the last round
            if (!w_last) begin
                r_round <= r_round + 4'd1;
            end
        end
    end

    assign out_block = r_state;
endmodule

`default_nettype wire

// File: tb/tb_aes128_enc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes128_enc_core
// Brief    : Self-checking bench for aes128_enc_core against a byte-array
//            AES-128 reference model with fully pre-expanded key schedule.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_aes128_enc_core;
    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;

    int tests_run;
    int tests_failed;

    logic [7:0] sbox_t [256];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    aes128_enc_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int unsigned x, y, p;
        x = a; y = b; p = 0;
        while (y != 0) begin
            if ((y & 1) != 0) p = p ^ x;
            x = x << 1;
            if ((x & 32'h100) != 0) x = x ^ 32'h11b;
            y = y >> 1;
        end
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] v;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            v = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (a != 0 && gmul(a[7:0], b[7:0]) == 8'h01) v = b[7:0];
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
            end
            sbox_t[a] = s;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   hold;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            w[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                hold = tmp[0];
                tmp[0] = sbox_t[tmp[1]] ^ rc;
                tmp[1] = sbox_t[tmp[2]];
                tmp[2] = sbox_t[tmp[3]];
                tmp[3] = sbox_t[hold];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = t[4*((c+row)%4)+row];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Runs one block; lat = edges from accept to out_valid, -1 on timeout
    task automatic do_encrypt(input logic [127:0] key, input logic [127:0] pt,
                              input bit scramble, input bit finish,
                              output logic [127:0] ct, output int lat);
        int waitc;
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 20) begin
            tick();
            waitc++;
        end
        in_key   = key;
        in_block = pt;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (scramble) begin
                in_block  = rand128();
                in_key    = rand128();
                in_valid  = $urandom_range(0, 1) == 1;
                out_ready = $urandom_range(0, 1) == 1;
            end
            tick();
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ct = out_block;
        if (lat >= 40) lat = -1;
        if (finish) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [127:0] ct;
        int lat;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_key = C1_KEY; in_block = C1_PT;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_block !== 128'h0) begin
                tests_failed++;
                $display("FAIL reset_state: in_ready=%b out_valid=%b out_block=%h, required 1 0 0",
                         in_ready, out_valid, out_block);
            end
        end
        rst = 1'b0; out_ready = 1'b0;
        tick();
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_accept_after_reset: in_ready=%b, required 0", in_ready);
        end
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        tests_run++;
        if (lat != 10 || out_block !== C1_CT) begin
            tests_failed++;
            $display("FAIL post_reset_c1: latency=%0d out_block=%h, required 10 %h", lat, out_block, C1_CT);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_kat(input logic [127:0] key, input logic [127:0] pt,
                            input logic [127:0] exp_ct);
        logic [127:0] ct;
        int lat;
        do_encrypt(key, pt, 1'b0, 1'b1, ct, lat);
        tests_run++;
        if (lat != 10) begin
            tests_failed++;
            $display("FAIL kat_latency: got %0d edges, required 10", lat);
        end
        tests_run++;
        if (ct !== exp_ct) begin
            tests_failed++;
            $display("FAIL kat_result: got %h, required %h", ct, exp_ct);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] ct;
        int lat;
        do_encrypt(B_KEY, B_PT, 1'b0, 1'b0, ct, lat);
        tests_run++;
        if (lat != 10 || ct !== B_CT) begin
            tests_failed++;
            $display("FAIL bp_result: latency=%0d out_block=%h, required 10 %h", lat, ct, B_CT);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = $urandom_range(0, 1) == 1;
            in_block = rand128();
            in_key   = rand128();
            tick();
            tests_run++;
            if (out_block !== B_CT || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_hold cycle %0d: out_block=%h in_ready=%b out_valid=%b, required %h 0 1",
                         i, out_block, in_ready, out_valid, B_CT);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_input_change();
        logic [127:0] ct;
        int lat;
        do_encrypt(C1_KEY, C1_PT, 1'b1, 1'b1, ct, lat);
        tests_run++;
        if (lat != 10 || ct !== C1_CT) begin
            tests_failed++;
            $display("FAIL input_change: latency=%0d out_block=%h, required 10 %h", lat, ct, C1_CT);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] ct;
        int lat;
        int seen;
        in_key = C1_KEY; in_block = C1_PT; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_block !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_state: in_ready=%b out_valid=%b out_block=%h, required 1 0 0",
                     in_ready, out_valid, out_block);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_abort: out_valid seen %0d cycles, required 0", seen);
        end
        do_encrypt(C1_KEY, C1_PT, 1'b0, 1'b1, ct, lat);
        tests_run++;
        if (lat != 10 || ct !== C1_CT) begin
            tests_failed++;
            $display("FAIL reset_mid_rerun: latency=%0d out_block=%h, required 10 %h", lat, ct, C1_CT);
        end
    endtask

    task automatic test_random(output logic [127:0] last_exp);
        logic [127:0] key, pt, exp_ct, ct;
        int lat;
        last_exp = '0;
        for (int n = 0; n < 16; n++) begin
            key = rand128();
            pt  = rand128();
            exp_ct = aes_ref(key, pt);
            do_encrypt(key, pt, (n % 2) == 1, 1'b1, ct, lat);
            tests_run++;
            if (lat != 10 || ct !== exp_ct) begin
                tests_failed++;
                $display("FAIL random_%0d: latency=%0d out_block=%h, required 10 %h", n, lat, ct, exp_ct);
            end
            last_exp = exp_ct;
        end
    endtask

    task automatic test_idle_out_ready(input logic [127:0] last_exp);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_block !== last_exp) begin
                tests_failed++;
                $display("FAIL idle_out_ready: in_ready=%b out_valid=%b out_block=%h, required 1 0 %h",
                         in_ready, out_valid, out_block, last_exp);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_key = C1_KEY; in_block = C1_PT;
        tick();
        in_key = B_KEY; in_block = B_PT;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        tests_run++;
        if (n != 10 || out_block !== C1_CT) begin
            tests_failed++;
            $display("FAIL b2b_first: latency=%0d out_block=%h, required 10 %h", n, out_block, C1_CT);
        end
        tick();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_handshake: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        tick();
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second_accept: in_ready=%b, required 0", in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        tests_run++;
        if (n != 10 || out_block !== B_CT) begin
            tests_failed++;
            $display("FAIL b2b_second: latency=%0d out_block=%h, required 10 %h", n, out_block, B_CT);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] last_exp;
        tests_run    = 0;
        tests_failed = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_block  = '0;
        in_key    = '0;
        build_sbox();

        test_reset();
        test_kat(C1_KEY, C1_PT, C1_CT);
        test_kat(B_KEY, B_PT, B_CT);
        test_backpressure();
        test_input_change();
        test_reset_mid();
        test_random(last_exp);
        test_idle_out_ready(last_exp);
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

`default_nettype wire
